// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, field positions,
// the decoded-instruction record and the combinational decoder.
package isa_pkg;

    localparam int ILEN   = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 6;
    localparam int IMM_W  = 16;

    localparam int OP_LSB = 26;
    localparam int RD_LSB = 21;
    localparam int RS_LSB = 16;
    localparam int RT_LSB = 11;

    localparam logic [OP_W-1:0] OP_NOP    = 6'h00;
    localparam logic [OP_W-1:0] OP_ALUR   = 6'h01;
    localparam logic [OP_W-1:0] OP_ALUI   = 6'h02;
    localparam logic [OP_W-1:0] OP_LOAD   = 6'h03;
    localparam logic [OP_W-1:0] OP_STORE  = 6'h04;
    localparam logic [OP_W-1:0] OP_BRANCH = 6'h05;

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} hold_state_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [ILEN-1:0]  imm;
        logic             wen;
        logic             reads_rs;
        logic             reads_rt;
        logic             reads_rd;
        logic             ill;
    } dec_t;

    function automatic dec_t decode(input logic [ILEN-1:0] isn);
        dec_t d;
        d     = '0;
        d.op  = isn[OP_LSB +: OP_W];
        d.rd  = isn[RD_LSB +: REG_W];
        d.rs  = isn[RS_LSB +: REG_W];
        d.rt  = isn[RT_LSB +: REG_W];
        d.imm = {{(ILEN-IMM_W){isn[IMM_W-1]}}, isn[IMM_W-1:0]};
        case (d.op)
            OP_NOP:           ;
            OP_ALUR:          begin d.reads_rs = 1'b1; d.reads_rt = 1'b1; d.wen = 1'b1; end
            OP_ALUI, OP_LOAD: begin d.reads_rs = 1'b1; d.wen = 1'b1; end
            OP_STORE:         begin d.reads_rs = 1'b1; d.reads_rd = 1'b1; end
            OP_BRANCH:        begin d.reads_rs = 1'b1; d.reads_rt = 1'b1; end
            default:          d.ill = 1'b1;
        endcase
        // Writes to r0 are architecturally discarded, so never track them.
        if (d.rd == '0) d.wen = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set on
// issue of a writer and cleared on writeback; r0 is never busy.
module id_scoreboard
    import isa_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic [REG_W-1:0] set_reg_i,
    input  logic             clr_i,
    input  logic [REG_W-1:0] clr_reg_i,
    input  logic [REG_W-1:0] rd_a_reg_i,
    input  logic [REG_W-1:0] rd_b_reg_i,
    input  logic [REG_W-1:0] wr_reg_i,
    output logic             rd_a_busy_o,
    output logic             rd_b_busy_o,
    output logic             wr_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear so a same-cycle set/clear leaves the bit busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_reg_i] = 1'b0;
        if (set_i) busy_d[set_reg_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign rd_a_busy_o = busy_q[rd_a_reg_i];
    assign rd_b_busy_o = busy_q[rd_b_reg_i];
    assign wr_busy_o   = busy_q[wr_reg_i];

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: holds one fetched instruction, checks it against
// the scoreboard and issues it to execute, back-pressuring fetch on hazards.
module id_stage
    import isa_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  isn,
    input  logic [XLEN-1:0]  n_pc,
    output logic             stall,
    input  logic             ex_stall,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_reg,
    output logic             de_valid,
    output logic [XLEN-1:0]  de_pc,
    output logic [OP_W-1:0]  de_op,
    output logic [REG_W-1:0] de_rd,
    output logic [REG_W-1:0] de_rs,
    output logic [REG_W-1:0] de_rt,
    output logic [XLEN-1:0]  de_imm,
    output logic             de_wen,
    output logic             de_ill
);

    hold_state_e      state_q, state_d;
    logic             cap;
    logic [XLEN-1:0]  h_isn_q, h_pc_q;
    dec_t             dec;
    logic             hv, hazard, issue;
    logic             rs_busy, rb_busy, wr_busy;
    logic [REG_W-1:0] rb_reg;

    assign hv  = (state_q == HELD);
    assign dec = decode(h_isn_q);

    // Second read port serves rt for ALU-R/BRANCH and rd for STORE.
    assign rb_reg = dec.reads_rt ? dec.rt : dec.rd;

    id_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_i       (issue & dec.wen),
        .set_reg_i   (dec.rd),
        .clr_i       (wb_valid),
        .clr_reg_i   (wb_reg),
        .rd_a_reg_i  (dec.rs),
        .rd_b_reg_i  (rb_reg),
        .wr_reg_i    (dec.rd),
        .rd_a_busy_o (rs_busy),
        .rd_b_busy_o (rb_busy),
        .wr_busy_o   (wr_busy)
    );

    assign hazard = hv & ((dec.reads_rs & rs_busy)
                        | ((dec.reads_rt | dec.reads_rd) & rb_busy)
                        | (dec.wen & wr_busy));
    assign issue  = hv & ~hazard & ~ex_stall & ~flush;
    assign stall  = hv & ~issue & ~flush;

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        case (state_q)
            EMPTY: if (!flush) begin
                state_d = HELD;
                cap     = 1'b1;
            end
            HELD: begin
                if (flush)      state_d = EMPTY;
                else if (issue) cap     = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            h_isn_q <= isn;
            h_pc_q  <= n_pc;
        end
    end

    // Fields only change on issue so a stalled or flushed slot keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_valid <= 1'b0;
            de_pc    <= '0;
            de_op    <= '0;
            de_rd    <= '0;
            de_rs    <= '0;
            de_rt    <= '0;
            de_imm   <= '0;
            de_wen   <= 1'b0;
            de_ill   <= 1'b0;
        end else if (flush) begin
            de_valid <= 1'b0;
        end else if (!ex_stall) begin
            de_valid <= issue;
            if (issue) begin
                de_pc  <= h_pc_q;
                de_op  <= dec.op;
                de_rd  <= dec.rd;
                de_rs  <= dec.rs;
                de_rt  <= dec.rt;
                de_imm <= dec.imm;
                de_wen <= dec.wen;
                de_ill <= dec.ill;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: streams hand-encoded instructions and checks
// issue timing, hazard stalls, scoreboard contents, flush and reset.
module tb_id_stage;
    import isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] isn, n_pc;
    logic        stall, ex_stall, flush, wb_valid;
    logic [4:0]  wb_reg;
    logic        de_valid, de_wen, de_ill;
    logic [31:0] de_pc, de_imm;
    logic [5:0]  de_op;
    logic [4:0]  de_rd, de_rs, de_rt;

    int ncmp = 0;
    int nfail = 0;

    id_stage #(.NREGS(32), .XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .isn      (isn),
        .n_pc     (n_pc),
        .stall    (stall),
        .ex_stall (ex_stall),
        .flush    (flush),
        .wb_valid (wb_valid),
        .wb_reg   (wb_reg),
        .de_valid (de_valid),
        .de_pc    (de_pc),
        .de_op    (de_op),
        .de_rd    (de_rd),
        .de_rs    (de_rs),
        .de_rt    (de_rt),
        .de_imm   (de_imm),
        .de_wen   (de_wen),
        .de_ill   (de_ill)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [15:0] lo);
        return {op, rd, rs, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; isn = '0; n_pc = '0; ex_stall = 1'b0; flush = 1'b0;
        wb_valid = 1'b0; wb_reg = '0;
        tick(); tick();
        chk("rst_de_valid", 32'(de_valid), 32'd0);
        chk("rst_de_pc", de_pc, 32'd0);
        chk("rst_de_op", 32'(de_op), 32'd0);
        chk("rst_de_imm", de_imm, 32'd0);
        chk("rst_de_wen", 32'(de_wen), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", dut.u_sb.busy_q, 32'd0);
        rst = 1'b0;

        // Four independent ALU-I writers r1..r4, one per cycle.
        for (int k = 1; k <= 4; k++) begin
            isn = enc(OP_ALUI, 5'(k), 5'd0, 16'(k)); n_pc = 32'h100 + 32'(4 * (k - 1));
            #1 chk("p1_stall", 32'(stall), 32'd0);
            tick();
            if (k == 1) chk("p1_first_invalid", 32'(de_valid), 32'd0);
            else begin
                chk("p1_valid", 32'(de_valid), 32'd1);
                chk("p1_pc", de_pc, 32'h100 + 32'(4 * (k - 2)));
                chk("p1_rd", 32'(de_rd), 32'(k - 1));
            end
        end
        isn = enc(OP_NOP, 5'd0, 5'd0, 16'd0); n_pc = 32'h110;
        #1 chk("p1_stall_last", 32'(stall), 32'd0);
        tick();
        chk("p1_valid_last", 32'(de_valid), 32'd1);
        chk("p1_pc_last", de_pc, 32'h10C);
        chk("p1_imm_last", de_imm, 32'd4);
        chk("p1_busy", dut.u_sb.busy_q, 32'h1E);

        // Retire r1..r4 while NOPs stream through.
        for (int r = 1; r <= 4; r++) begin
            isn = enc(OP_NOP, 5'd0, 5'd0, 16'd0); n_pc = 32'h110 + 32'(4 * r);
            wb_valid = 1'b1; wb_reg = 5'(r);
            tick();
            chk("wb_nop_pc", de_pc, 32'h110 + 32'(4 * (r - 1)));
        end
        wb_valid = 1'b0;
        chk("wb_busy_clear", dut.u_sb.busy_q, 32'd0);

        // RAW hazard: ALU-R r3 <- r1,r2 right behind ALU-I writing r1 (negative imm).
        isn = enc(OP_ALUI, 5'd1, 5'd0, 16'hFFFF); n_pc = 32'h200;
        tick();
        chk("nop_wen", 32'(de_wen), 32'd0);
        isn = enc(OP_ALUR, 5'd3, 5'd1, {5'd2, 11'd0}); n_pc = 32'h204;
        #1 chk("raw_pre_stall", 32'(stall), 32'd0);
        tick();
        chk("alui_pc", de_pc, 32'h200);
        chk("alui_imm_sext", de_imm, 32'hFFFF_FFFF);
        chk("alui_op", 32'(de_op), 32'(OP_ALUI));
        chk("raw_stall", 32'(stall), 32'd1);
        tick();
        chk("raw_hold_invalid", 32'(de_valid), 32'd0);
        chk("raw_stall2", 32'(stall), 32'd1);
        tick();
        wb_valid = 1'b1; wb_reg = 5'd1;
        #1 chk("raw_no_bypass", 32'(stall), 32'd1);
        tick();
        wb_valid = 1'b0;
        chk("raw_wb_edge_invalid", 32'(de_valid), 32'd0);
        chk("raw_released", 32'(stall), 32'd0);
        isn = enc(OP_ALUI, 5'd5, 5'd0, 16'd5); n_pc = 32'h208;
        tick();
        chk("raw_issue_valid", 32'(de_valid), 32'd1);
        chk("raw_issue_pc", de_pc, 32'h204);
        chk("raw_issue_fields", {17'd0, de_rd, de_rs, de_rt}, {17'd0, 5'd3, 5'd1, 5'd2});
        chk("raw_busy3", 32'(dut.u_sb.busy_q[3]), 32'd1);

        // Writeback of r5 on the same edge a new writer of r5 issues.
        isn = enc(OP_ALUI, 5'd6, 5'd0, 16'd6); n_pc = 32'h20C;
        wb_valid = 1'b1; wb_reg = 5'd5;
        #1 chk("setclr_stall", 32'(stall), 32'd0);
        tick();
        wb_valid = 1'b0;
        chk("setclr_pc", de_pc, 32'h208);
        chk("setclr_busy5", 32'(dut.u_sb.busy_q[5]), 32'd1);

        // Downstream stall for three cycles.
        isn = enc(OP_LOAD, 5'd7, 5'd0, 16'd8); n_pc = 32'h210;
        ex_stall = 1'b1;
        #1 chk("exs_stall", 32'(stall), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("exs_valid_frozen", 32'(de_valid), 32'd1);
            chk("exs_pc_frozen", de_pc, 32'h208);
            chk("exs_rd_frozen", 32'(de_rd), 32'd5);
            chk("exs_stall_held", 32'(stall), 32'd1);
            chk("exs_busy", dut.u_sb.busy_q, 32'h28);
        end
        ex_stall = 1'b0;
        #1 chk("exs_release", 32'(stall), 32'd0);
        tick();
        chk("exs_resume_pc", de_pc, 32'h20C);
        isn = enc(OP_STORE, 5'd3, 5'd0, 16'd0); n_pc = 32'h214;
        tick();
        chk("exs_next_pc", de_pc, 32'h210);
        chk("load_op", 32'(de_op), 32'(OP_LOAD));
        chk("busy_after_load", dut.u_sb.busy_q, 32'hE8);

        // Flush (together with ex_stall) while a STORE waits on busy r3.
        #1 chk("store_hazard", 32'(stall), 32'd1);
        flush = 1'b1; ex_stall = 1'b1;
        #1 chk("flush_stall_drop", 32'(stall), 32'd0);
        tick();
        flush = 1'b0; ex_stall = 1'b0;
        chk("flush_invalid", 32'(de_valid), 32'd0);
        chk("flush_busy_kept", dut.u_sb.busy_q, 32'hE8);
        chk("flush_empty_stall", 32'(stall), 32'd0);

        // Illegal opcode, then an ALU-I targeting r0.
        isn = enc(6'h3F, 5'd2, 5'd0, 16'd0); n_pc = 32'h300;
        tick();
        chk("ill_capture_invalid", 32'(de_valid), 32'd0);
        isn = enc(OP_ALUI, 5'd0, 5'd0, 16'h7FFF); n_pc = 32'h304;
        tick();
        chk("ill_valid", 32'(de_valid), 32'd1);
        chk("ill_pc", de_pc, 32'h300);
        chk("ill_flag", 32'(de_ill), 32'd1);
        chk("ill_wen", 32'(de_wen), 32'd0);
        chk("ill_busy", dut.u_sb.busy_q, 32'hE8);
        isn = enc(OP_NOP, 5'd0, 5'd0, 16'd0); n_pc = 32'h308;
        tick();
        chk("r0_pc", de_pc, 32'h304);
        chk("r0_wen", 32'(de_wen), 32'd0);
        chk("r0_imm", de_imm, 32'h0000_7FFF);
        chk("r0_ill", 32'(de_ill), 32'd0);
        chk("r0_busy", dut.u_sb.busy_q, 32'hE8);

        // Asynchronous reset while stalled on a hazard.
        isn = enc(OP_STORE, 5'd3, 5'd0, 16'd0); n_pc = 32'h30C;
        tick();
        #1 chk("arst_pre_stall", 32'(stall), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_valid", 32'(de_valid), 32'd0);
        chk("arst_pc", de_pc, 32'd0);
        chk("arst_busy", dut.u_sb.busy_q, 32'd0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
